// File: rtl/s2_serial_receiver_pkg.sv
// Shared constants, state encoding and helpers for the S2 serial receiver.
package s2_pkg;

    localparam int NBYTES  = 18;
    localparam int PAW     = 3;
    localparam int DW      = 8;
    localparam int RBAW    = 5;
    localparam int PKG_LEN = PAW + NBYTES;
    localparam int CNTW    = 5;

    localparam logic RB_RD = 1'b1;
    localparam logic RB_WR = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        COMMIT = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Package a carries bit DW-1-a of every byte; with DW == 2**PAW that is ~a.
    function automatic logic [PAW-1:0] col_index(input logic [PAW-1:0] a);
        return ~a;
    endfunction

endpackage

// File: rtl/s2_serial_receiver_if.sv
// Bundle of the sen/sd link wires and the RB2 write port.
interface s2_serial_receiver_if;
    import s2_pkg::*;

    logic            sen;
    logic            sd;
    logic            RB2_RW;
    logic [RBAW-1:0] RB2_A;
    logic [DW-1:0]   RB2_D;
    logic            S2_done;

    // Receiver side.
    modport slave (
        input  sen,
        input  sd,
        output RB2_RW,
        output RB2_A,
        output RB2_D,
        output S2_done
    );

    // Link driver / RB2 observer side.
    modport master (
        output sen,
        output sd,
        input  RB2_RW,
        input  RB2_A,
        input  RB2_D,
        input  S2_done
    );

endinterface

// File: rtl/s2_serial_receiver_deframer.sv
// Deframes one 21-bit package from sen/sd and presents it for one cycle.
//
//  state  | meaning
//  IDLE   | waiting for sen low; a low sample is bit 0 of a new package
//  SHIFT  | collecting bits while sen low; bitcnt saturates at PKG_LEN
//  COMMIT | package complete, o_pkg_valid high for this cycle
module s2_deframer
    import s2_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_sen,
    input  logic              i_sd,
    output logic              o_pkg_valid,
    output logic [PAW-1:0]    o_pkg_addr,
    output logic [NBYTES-1:0] o_pkg_data
);

    state_t              r_state;
    state_t              w_state_next;
    logic [CNTW-1:0]     r_bitcnt;
    logic [PKG_LEN-1:0]  r_shift;
    logic                r_overrun;
    logic                w_full;

    assign w_full = (r_bitcnt == CNTW'(PKG_LEN));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next state; COMMIT also accepts a new start bit so one idle cycle is enough.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, COMMIT: w_state_next = i_sen ? IDLE : SHIFT;
            SHIFT: begin
                if (i_sen) w_state_next = (w_full && !r_overrun) ? COMMIT : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Shift register, bit counter and overrun flag for a 22nd bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                IDLE, COMMIT: begin
                    if (!i_sen) begin
                        r_shift   <= {r_shift[PKG_LEN-2:0], i_sd};
                        r_bitcnt  <= CNTW'(1);
                        r_overrun <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!i_sen) begin
                        if (w_full) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_shift  <= {r_shift[PKG_LEN-2:0], i_sd};
                            r_bitcnt <= r_bitcnt + CNTW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // After 21 shifts the address sits on top and r_shift[j] belongs to byte j.
    assign o_pkg_valid = (r_state == COMMIT);
    assign o_pkg_addr  = r_shift[PKG_LEN-1 -: PAW];
    assign o_pkg_data  = r_shift[NBYTES-1:0];

endmodule

// File: rtl/s2_serial_receiver.sv
// S2 receiver top: assembles byte columns from packages, then bursts 18 bytes into RB2.
//
//  state | meaning
//  IDLE  | collecting packages into the byte buffer and rcv_mask
//  WRITE | one RB2 write per cycle, addresses 0..NBYTES-1
//  DONE  | burst finished, S2_done held until reset
module s2_serial_receiver
    import s2_pkg::*;
(
    input  logic clk,
    input  logic rst,
    s2_serial_receiver_if.slave bus
);

    localparam logic [DW-1:0] MASK_ALL = {DW{1'b1}};

    logic              w_pkg_valid;
    logic [PAW-1:0]    w_pkg_addr;
    logic [NBYTES-1:0] w_pkg_data;

    state_t            r_state;
    state_t            w_state_next;
    logic [DW-1:0]     r_buf [NBYTES];
    logic [DW-1:0]     w_col_buf [NBYTES];
    logic [DW-1:0]     r_mask;
    logic [DW-1:0]     w_mask_next;
    logic              r_rb2_rw;
    logic [RBAW-1:0]   r_rb2_a;
    logic [RBAW-1:0]   w_a_inc;
    logic [DW-1:0]     r_rb2_d;
    logic              r_done;

    s2_deframer u_deframer (
        .clk         (clk),
        .rst         (rst),
        .i_sen       (bus.sen),
        .i_sd        (bus.sd),
        .o_pkg_valid (w_pkg_valid),
        .o_pkg_addr  (w_pkg_addr),
        .o_pkg_data  (w_pkg_data)
    );

    assign w_mask_next = r_mask | (DW'(1) << w_pkg_addr);
    assign w_a_inc     = r_rb2_a + RBAW'(1);

    // Buffer image with the incoming package column merged in.
    always_comb begin
        for (int j = 0; j < NBYTES; j++) begin
            w_col_buf[j] = r_buf[j];
            w_col_buf[j][col_index(w_pkg_addr)] = w_pkg_data[j];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next state: start the burst on the package that completes the mask.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_pkg_valid && (w_mask_next == MASK_ALL)) w_state_next = WRITE;
            WRITE:   if (r_rb2_a == RBAW'(NBYTES - 1)) w_state_next = DONE;
            DONE:    w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end

    // Byte buffer and receive mask; packages are ignored once the burst starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NBYTES; j++) r_buf[j] <= '0;
            r_mask <= '0;
        end else if ((r_state == IDLE) && w_pkg_valid) begin
            r_buf  <= w_col_buf;
            r_mask <= w_mask_next;
        end
    end

    // RB2 port registers; byte 0 comes from the merged image so the burst starts in the commit cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rb2_rw <= RB_RD;
            r_rb2_a  <= '0;
            r_rb2_d  <= '0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_state_next == WRITE) begin
                        r_rb2_rw <= RB_WR;
                        r_rb2_a  <= '0;
                        r_rb2_d  <= w_col_buf[0];
                    end
                end
                WRITE: begin
                    if (w_state_next == DONE) begin
                        r_rb2_rw <= RB_RD;
                        r_done   <= 1'b1;
                    end else begin
                        r_rb2_a <= w_a_inc;
                        r_rb2_d <= r_buf[w_a_inc];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.RB2_RW  = r_rb2_rw;
    assign bus.RB2_A   = r_rb2_a;
    assign bus.RB2_D   = r_rb2_d;
    assign bus.S2_done = r_done;

endmodule

// File: tb/tb_s2_serial_receiver.sv
// Self-checking bench for s2_serial_receiver with a column-image reference model.
module tb_s2_serial_receiver;
    import s2_pkg::*;

    typedef logic [7:0] img_t [NBYTES];

    logic clk = 1'b0;
    logic rst = 1'b1;

    s2_serial_receiver_if bus();

    s2_serial_receiver dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected RB2 image: byte j, bit (7-a) comes from the last valid package a.
    img_t mdl_img;

    logic [4:0] wq_a[$];
    logic [7:0] wq_d[$];

    // Record every write cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && bus.RB2_RW === 1'b0) begin
            wq_a.push_back(bus.RB2_A);
            wq_d.push_back(bus.RB2_D);
        end
    end

    task automatic clear_model();
        wq_a.delete();
        wq_d.delete();
        for (int j = 0; j < NBYTES; j++) mdl_img[j] = 8'h00;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.sen = 1'b1;
        bus.sd  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic rand_img(output img_t b);
        for (int j = 0; j < NBYTES; j++) b[j] = 8'($urandom);
    endtask

    // Drive nbits of a package (21 is a well-formed frame) then one idle cycle.
    task automatic send_pkg(input int a, input img_t b, input int nbits);
        for (int n = 0; n < nbits; n++) begin
            @(negedge clk);
            bus.sen = 1'b0;
            if (n < 3)
                bus.sd = ((a >> (2 - n)) & 1) != 0;
            else if (n < 3 + NBYTES)
                bus.sd = b[NBYTES - 1 - (n - 3)][7 - a];
            else
                bus.sd = ($urandom % 2) != 0;
        end
        @(negedge clk);
        bus.sen = 1'b1;
        bus.sd  = ($urandom % 2) != 0;
        if (nbits == PKG_LEN)
            for (int j = 0; j < NBYTES; j++) mdl_img[j][7 - a] = b[j][7 - a];
    endtask

    // Count posedges after the final sen rise; -1 means not seen within the budget.
    task automatic wait_done(output int first_wr, output int done_cyc);
        first_wr = -1;
        done_cyc = -1;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk);
            #1;
            if (first_wr < 0 && bus.RB2_RW === 1'b0) first_wr = c;
            if (bus.S2_done === 1'b1) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.RB2_RW !== 1'b1) begin errors++; $display("FAIL reset_rw got %0b want 1", bus.RB2_RW); end
        checks++; if (bus.RB2_A !== 5'd0) begin errors++; $display("FAIL reset_a got %0d want 0", bus.RB2_A); end
        checks++; if (bus.RB2_D !== 8'h00) begin errors++; $display("FAIL reset_d got %0h want 0", bus.RB2_D); end
        checks++; if (bus.S2_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", bus.S2_done); end
    endtask

    task automatic test_nominal();
        img_t b;
        int fw, dc;
        do_reset();
        for (int i = 0; i < NBYTES; i++) b[i] = 8'(8'h11 * i);
        for (int a = 0; a < 8; a++) send_pkg(a, b, PKG_LEN);
        wait_done(fw, dc);
        // Detect edge + commit edge, then 18 one-cycle writes, then S2_done.
        checks++; if (fw != 2) begin errors++; $display("FAIL nominal_first_write got %0d want 2", fw); end
        checks++; if (dc != 2 + NBYTES) begin errors++; $display("FAIL nominal_done_latency got %0d want %0d", dc, 2 + NBYTES); end
        checks++; if (wq_a.size() != NBYTES) begin errors++; $display("FAIL nominal_count got %0d want %0d", wq_a.size(), NBYTES); end
        for (int i = 0; i < wq_a.size() && i < NBYTES; i++) begin
            checks++;
            if (wq_a[i] !== 5'(i) || wq_d[i] !== 8'(8'h11 * i) || wq_d[i] !== mdl_img[i]) begin
                errors++; $display("FAIL nominal_write%0d got A=%0d D=%0h want A=%0d D=%0h", i, wq_a[i], wq_d[i], i, mdl_img[i]);
            end
        end
        repeat (4) @(negedge clk);
        checks++; if (bus.S2_done !== 1'b1 || bus.RB2_RW !== 1'b1 || bus.RB2_A !== 5'(NBYTES - 1)) begin
            errors++; $display("FAIL nominal_hold got done=%0b rw=%0b A=%0d want 1 1 %0d", bus.S2_done, bus.RB2_RW, bus.RB2_A, NBYTES - 1);
        end
    endtask

    task automatic test_out_of_order();
        img_t b;
        int order [8] = '{5, 2, 7, 0, 1, 6, 3, 4};
        int fw, dc;
        do_reset();
        for (int i = 0; i < NBYTES; i++) b[i] = 8'(8'hA5 ^ i);
        for (int k = 0; k < 7; k++) send_pkg(order[k], b, PKG_LEN);
        repeat (5) @(negedge clk);
        checks++; if (wq_a.size() != 0 || bus.S2_done !== 1'b0) begin
            errors++; $display("FAIL ooo_early got writes=%0d done=%0b want 0 0", wq_a.size(), bus.S2_done);
        end
        send_pkg(order[7], b, PKG_LEN);
        wait_done(fw, dc);
        checks++; if (dc != 2 + NBYTES) begin errors++; $display("FAIL ooo_done got %0d want %0d", dc, 2 + NBYTES); end
        checks++; if (wq_a.size() != NBYTES) begin errors++; $display("FAIL ooo_count got %0d want %0d", wq_a.size(), NBYTES); end
        for (int i = 0; i < wq_a.size() && i < NBYTES; i++) begin
            checks++;
            if (wq_a[i] !== 5'(i) || wq_d[i] !== mdl_img[i]) begin
                errors++; $display("FAIL ooo_write%0d got A=%0d D=%0h want A=%0d D=%0h", i, wq_a[i], wq_d[i], i, mdl_img[i]);
            end
        end
    endtask

    task automatic test_short_frame();
        img_t b, bad;
        int fw, dc;
        do_reset();
        rand_img(b);
        rand_img(bad);
        send_pkg(3, bad, PKG_LEN - 1);
        for (int a = 0; a < 8; a++) if (a != 3) send_pkg(a, b, PKG_LEN);
        repeat (5) @(negedge clk);
        checks++; if (wq_a.size() != 0 || bus.S2_done !== 1'b0) begin
            errors++; $display("FAIL short_ignored got writes=%0d done=%0b want 0 0", wq_a.size(), bus.S2_done);
        end
        send_pkg(3, b, PKG_LEN);
        wait_done(fw, dc);
        checks++; if (dc != 2 + NBYTES) begin errors++; $display("FAIL short_done got %0d want %0d", dc, 2 + NBYTES); end
        checks++; if (wq_a.size() != NBYTES) begin errors++; $display("FAIL short_count got %0d want %0d", wq_a.size(), NBYTES); end
        for (int i = 0; i < wq_a.size() && i < NBYTES; i++) begin
            checks++;
            if (wq_a[i] !== 5'(i) || wq_d[i] !== mdl_img[i]) begin
                errors++; $display("FAIL short_write%0d got A=%0d D=%0h want A=%0d D=%0h", i, wq_a[i], wq_d[i], i, mdl_img[i]);
            end
        end
    endtask

    task automatic test_long_frame();
        img_t b, bad;
        int fw, dc;
        do_reset();
        rand_img(b);
        rand_img(bad);
        for (int a = 0; a < 8; a++) begin
            if (a == 6) send_pkg(6, bad, PKG_LEN + 1);
            else        send_pkg(a, b, PKG_LEN);
        end
        repeat (5) @(negedge clk);
        checks++; if (wq_a.size() != 0 || bus.S2_done !== 1'b0) begin
            errors++; $display("FAIL long_ignored got writes=%0d done=%0b want 0 0", wq_a.size(), bus.S2_done);
        end
        send_pkg(6, b, PKG_LEN);
        wait_done(fw, dc);
        checks++; if (dc != 2 + NBYTES) begin errors++; $display("FAIL long_done got %0d want %0d", dc, 2 + NBYTES); end
        checks++; if (wq_a.size() != NBYTES) begin errors++; $display("FAIL long_count got %0d want %0d", wq_a.size(), NBYTES); end
        for (int i = 0; i < wq_a.size() && i < NBYTES; i++) begin
            checks++;
            if (wq_a[i] !== 5'(i) || wq_d[i] !== mdl_img[i]) begin
                errors++; $display("FAIL long_write%0d got A=%0d D=%0h want A=%0d D=%0h", i, wq_a[i], wq_d[i], i, mdl_img[i]);
            end
        end
    endtask

    task automatic test_duplicate();
        img_t x, y;
        int fw, dc;
        do_reset();
        rand_img(x);
        rand_img(y);
        send_pkg(1, x, PKG_LEN);
        send_pkg(1, y, PKG_LEN);
        for (int a = 0; a < 8; a++) if (a != 1) send_pkg(a, y, PKG_LEN);
        wait_done(fw, dc);
        checks++; if (dc != 2 + NBYTES) begin errors++; $display("FAIL dup_done got %0d want %0d", dc, 2 + NBYTES); end
        for (int i = 0; i < wq_a.size() && i < NBYTES; i++) begin
            checks++;
            if (wq_a[i] !== 5'(i) || wq_d[i] !== y[i] || wq_d[i] !== mdl_img[i]) begin
                errors++; $display("FAIL dup_write%0d got A=%0d D=%0h want A=%0d D=%0h", i, wq_a[i], wq_d[i], i, y[i]);
            end
        end
        send_pkg(3, x, PKG_LEN);
        repeat (6) @(negedge clk);
        checks++; if (wq_a.size() != NBYTES || bus.S2_done !== 1'b1) begin
            errors++; $display("FAIL dup_no_extra got writes=%0d done=%0b want %0d 1", wq_a.size(), bus.S2_done, NBYTES);
        end
    endtask

    task automatic test_reset_mid_burst();
        img_t b;
        int fw, dc;
        bit found;
        do_reset();
        rand_img(b);
        for (int a = 0; a < 8; a++) send_pkg(a, b, PKG_LEN);
        found = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.RB2_RW === 1'b0 && bus.RB2_A === 5'd9) begin
                found = 1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL rstmid_reach got A=%0d want 9", bus.RB2_A); end
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.RB2_RW !== 1'b1 || bus.RB2_A !== 5'd0 || bus.RB2_D !== 8'h00 || bus.S2_done !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs got %0b/%0d/%0h/%0b want 1/0/0/0", bus.RB2_RW, bus.RB2_A, bus.RB2_D, bus.S2_done);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        rand_img(b);
        for (int a = 0; a < 7; a++) send_pkg(a, b, PKG_LEN);
        repeat (5) @(negedge clk);
        checks++; if (wq_a.size() != 0 || bus.S2_done !== 1'b0) begin
            errors++; $display("FAIL rstmid_mask_cleared got writes=%0d done=%0b want 0 0", wq_a.size(), bus.S2_done);
        end
        send_pkg(7, b, PKG_LEN);
        wait_done(fw, dc);
        checks++; if (dc != 2 + NBYTES) begin errors++; $display("FAIL rstmid_done got %0d want %0d", dc, 2 + NBYTES); end
        checks++; if (wq_a.size() != NBYTES) begin errors++; $display("FAIL rstmid_count got %0d want %0d", wq_a.size(), NBYTES); end
        for (int i = 0; i < wq_a.size() && i < NBYTES; i++) begin
            checks++;
            if (wq_a[i] !== 5'(i) || wq_d[i] !== mdl_img[i]) begin
                errors++; $display("FAIL rstmid_write%0d got A=%0d D=%0h want A=%0d D=%0h", i, wq_a[i], wq_d[i], i, mdl_img[i]);
            end
        end
    endtask

    initial begin
        bus.sen = 1'b1;
        bus.sd  = 1'b0;
        test_reset();
        test_nominal();
        test_out_of_order();
        test_short_frame();
        test_long_frame();
        test_duplicate();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
